// File: rtl/lcd_timing_pattern_gen_pkg.sv
// Shared types and RGB565 colour constants for the LCD timing and pattern generator.
package lcd_pkg;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_GRID  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_t;

    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int RGB_W = R_W + G_W + B_W;

    localparam logic [RGB_W-1:0] RED     = 16'hF800;
    localparam logic [RGB_W-1:0] GREEN   = 16'h07E0;
    localparam logic [RGB_W-1:0] BLUE    = 16'h001F;
    localparam logic [RGB_W-1:0] YELLOW  = 16'hFFE0;
    localparam logic [RGB_W-1:0] MAGENTA = 16'hF81F;
    localparam logic [RGB_W-1:0] CYAN    = 16'h07FF;
    localparam logic [RGB_W-1:0] WHITE   = 16'hFFFF;
    localparam logic [RGB_W-1:0] GRAY    = 16'h8410;
    localparam logic [RGB_W-1:0] BLACK   = 16'h0000;

    function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = RED;
            3'd1:    bar_color = GREEN;
            3'd2:    bar_color = BLUE;
            3'd3:    bar_color = YELLOW;
            3'd4:    bar_color = MAGENTA;
            3'd5:    bar_color = CYAN;
            3'd6:    bar_color = WHITE;
            default: bar_color = GRAY;
        endcase
    endfunction

endpackage

// File: rtl/lcd_timing_pattern_gen_if.sv
// Pattern-control inputs and RGB LCD pin bundle for lcd_timing_pattern_gen.
// No handshake: the generator streams one pixel per PixelClk; Mode/SolidColor are level inputs.
interface lcd_timing_pattern_gen_if;
    import lcd_pkg::*;

    logic [1:0]       Mode;
    logic [RGB_W-1:0] SolidColor;
    logic             LCD_DE;
    logic             LCD_HSYNC;
    logic             LCD_VSYNC;
    logic [R_W-1:0]   LCD_R;
    logic [G_W-1:0]   LCD_G;
    logic [B_W-1:0]   LCD_B;
    logic             FrameStart;
    logic [1:0]       ActiveMode;

    modport master (
        output Mode, SolidColor,
        input  LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B, FrameStart, ActiveMode
    );

    modport slave (
        input  Mode, SolidColor,
        output LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B, FrameStart, ActiveMode
    );

endinterface

// File: rtl/lcd_timing_pattern_gen_pattern_src.sv
// Pattern source: bar/pitch counters and combinational RGB565 colour for the current pixel.
// LCD_PATTERN_SCROLL_EN adds a per-frame horizontal scroll offset.
module lcd_pattern_src
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE   = 480,
    parameter int GRID_PITCH = 16,
    parameter int CW         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de,
    input  logic             x_load,
    input  logic             y_load,
    input  logic             y_adv,
    input  logic             frame_end,
    input  mode_t            active_mode,
    input  logic [RGB_W-1:0] solid,
    output logic [RGB_W-1:0] rgb
);

    localparam int BW = H_ACTIVE / 8;
    localparam int PW = (GRID_PITCH > 2) ? $clog2(GRID_PITCH) : 1;

    // Column state for one scrolled x position: bar index/remaining width and pitch phase.
    typedef struct packed {
        logic [CW-1:0] xs;
        logic [2:0]    bar;
        logic [CW-1:0] rem;
        logic [PW-1:0] col;
        logic          par;
    } col_t;

    function automatic col_t col_zero();
        col_zero     = '0;
        col_zero.rem = CW'(BW);
    endfunction

    function automatic col_t col_step(input col_t c);
        col_step = c;
        if (c.xs == CW'(H_ACTIVE - 1)) begin
            col_step = col_zero();
        end else begin
            col_step.xs = c.xs + CW'(1);
            // The last bar never advances, so it absorbs the remainder pixels.
            if (c.bar != 3'd7) begin
                if (c.rem == CW'(1)) begin
                    col_step.bar = c.bar + 3'd1;
                    col_step.rem = CW'(BW);
                end else begin
                    col_step.rem = c.rem - CW'(1);
                end
            end
            if (c.col == PW'(GRID_PITCH - 1)) begin
                col_step.col = '0;
                col_step.par = ~c.par;
            end else begin
                col_step.col = c.col + PW'(1);
            end
        end
    endfunction

    col_t          cur;
    col_t          org;
    logic [PW-1:0] row;
    logic          row_par;

`ifdef LCD_PATTERN_SCROLL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            org <= col_zero();
        end else if (frame_end) begin
            org <= col_step(org);
        end
    end
`else
    logic unused_frame_end;
    assign unused_frame_end = frame_end;
    assign org              = col_zero();
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= col_zero();
            row     <= '0;
            row_par <= 1'b0;
        end else begin
            if (x_load) begin
                cur <= org;
            end else if (de) begin
                cur <= col_step(cur);
            end
            if (y_load) begin
                row     <= '0;
                row_par <= 1'b0;
            end else if (y_adv) begin
                if (row == PW'(GRID_PITCH - 1)) begin
                    row     <= '0;
                    row_par <= ~row_par;
                end else begin
                    row <= row + PW'(1);
                end
            end
        end
    end

    always_comb begin
        rgb = BLACK;
        if (de) begin
            case (active_mode)
                MODE_BARS:  rgb = bar_color(cur.bar);
                MODE_SOLID: rgb = solid;
                MODE_GRID:  rgb = (cur.col == '0 || row == '0) ? WHITE : BLACK;
                MODE_CHECK: rgb = (cur.par ^ row_par) ? WHITE : BLACK;
                default:    rgb = BLACK;
            endcase
        end
    end

endmodule

// File: rtl/lcd_timing_pattern_gen.sv
// Parametrised LCD raster timing (HSYNC/VSYNC/DE) with four test patterns, all outputs registered.
// LCD_PATTERN_SCROLL_EN enables horizontal pattern scrolling inside lcd_pattern_src.
module lcd_timing_pattern_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE   = 480,
    parameter int H_FP       = 50,
    parameter int H_SYNC     = 4,
    parameter int H_BP       = 30,
    parameter int V_ACTIVE   = 272,
    parameter int V_FP       = 20,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 5,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int GRID_PITCH = 16,
    parameter int CW         = 16
) (
    input logic                      PixelClk,
    input logic                      RST,
    lcd_timing_pattern_gen_if.slave  bus
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;

    logic [CW-1:0]    h_cnt;
    logic [CW-1:0]    v_cnt;
    mode_t            active_mode;
    logic [RGB_W-1:0] solid_q;
    logic             line_end, frame_end;
    logic             hs_act, vs_act, h_de, v_de, de;
    logic             x_load, y_load, y_adv;
    logic [RGB_W-1:0] rgb;

    logic             de_q, hs_q, vs_q, fs_q;
    logic [RGB_W-1:0] rgb_q;

    assign line_end  = (h_cnt == CW'(H_TOTAL - 1));
    assign frame_end = line_end && (v_cnt == CW'(V_TOTAL - 1));
    assign hs_act    = (h_cnt < CW'(H_SYNC));
    assign vs_act    = (v_cnt < CW'(V_SYNC));
    assign h_de      = (h_cnt >= CW'(H_START)) && (h_cnt < CW'(H_START + H_ACTIVE));
    assign v_de      = (v_cnt >= CW'(V_START)) && (v_cnt < CW'(V_START + V_ACTIVE));
    assign de        = h_de && v_de;
    // Column state is primed one pixel early; row state on the line before the first active line.
    assign x_load    = (h_cnt == CW'(H_START - 1));
    assign y_load    = line_end && (v_cnt == CW'(V_START - 1));
    assign y_adv     = line_end && v_de;

    always_ff @(posedge PixelClk) begin
        if (RST) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            active_mode <= MODE_BARS;
            solid_q     <= '0;
        end else begin
            h_cnt <= line_end ? '0 : h_cnt + CW'(1);
            if (line_end) begin
                v_cnt <= (v_cnt == CW'(V_TOTAL - 1)) ? '0 : v_cnt + CW'(1);
            end
            if (frame_end) begin
                active_mode <= mode_t'(bus.Mode);
                solid_q     <= bus.SolidColor;
            end
        end
    end

    lcd_pattern_src #(
        .H_ACTIVE   (H_ACTIVE),
        .GRID_PITCH (GRID_PITCH),
        .CW         (CW)
    ) u_src (
        .clk         (PixelClk),
        .rst         (RST),
        .de          (de),
        .x_load      (x_load),
        .y_load      (y_load),
        .y_adv       (y_adv),
        .frame_end   (frame_end),
        .active_mode (active_mode),
        .solid       (solid_q),
        .rgb         (rgb)
    );

    always_ff @(posedge PixelClk) begin
        if (RST) begin
            de_q  <= 1'b0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            rgb_q <= '0;
            fs_q  <= 1'b0;
        end else begin
            de_q  <= de;
            hs_q  <= hs_act ? HS_POL : ~HS_POL;
            vs_q  <= vs_act ? VS_POL : ~VS_POL;
            rgb_q <= rgb;
            fs_q  <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign bus.LCD_DE     = de_q;
    assign bus.LCD_HSYNC  = hs_q;
    assign bus.LCD_VSYNC  = vs_q;
    assign bus.LCD_R      = rgb_q[RGB_W-1 -: R_W];
    assign bus.LCD_G      = rgb_q[B_W +: G_W];
    assign bus.LCD_B      = rgb_q[B_W-1:0];
    assign bus.FrameStart = fs_q;
    assign bus.ActiveMode = active_mode;

endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// Scoreboard bench for lcd_timing_pattern_gen on a small 22x7 raster with a raster-level reference model.
module tb_lcd_timing_pattern_gen;

    localparam int HA = 16, HFP = 2, HS = 2, HB = 2;
    localparam int VA = 4,  VFP = 1, VS = 1, VB = 1;
    localparam int P  = 4;
    localparam int HT = HS + HB + HA + HFP;
    localparam int VT = VS + VB + VA + VFP;
    localparam int BW = HA / 8;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst;
    lcd_timing_pattern_gen_if bus();

    lcd_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .GRID_PITCH(P), .CW(16)
    ) dut (
        .PixelClk (clk),
        .RST      (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] bars [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0,
                              16'hF81F, 16'h07FF, 16'hFFFF, 16'h8410};

    // Expected vector: {de, hsync, vsync, rgb[15:0], frame_start, active_mode[1:0]}
    logic [21:0] exp_q[$];
    int          tag_h_q[$];
    int          tag_v_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    int          mh = 0, mv = 0, mmode = 0, ms = 0;
    logic [15:0] msolid = 16'h0;

    function automatic logic [21:0] model_pixel(input int h, input int v, input int mode,
                                                input logic [15:0] solid, input int s);
        logic        de;
        logic [15:0] rgb;
        int          x, y, xs, bi;
        de  = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        x   = h - (HS + HB);
        y   = v - (VS + VB);
        xs  = (x + s) % HA;
        rgb = 16'h0;
        if (de) begin
            case (mode)
                0: begin
                    bi = xs / BW;
                    if (bi > 7) bi = 7;
                    rgb = bars[bi];
                end
                1: rgb = solid;
                2: rgb = ((xs % P == 0) || (y % P == 0)) ? 16'hFFFF : 16'h0000;
                default: rgb = ((((xs / P) ^ (y / P)) & 1) == 1) ? 16'hFFFF : 16'h0000;
            endcase
        end
        return {de, (h < HS) ? 1'b0 : 1'b1, (v < VS) ? 1'b0 : 1'b1, rgb,
                (h == 0 && v == 0) ? 1'b1 : 1'b0, 2'b00};
    endfunction

    // One clock edge: advance the reference raster with the inputs the DUT sampled.
    task automatic tick();
        logic [21:0] e;
        @(posedge clk);
        if (rst) begin
            e      = {1'b0, 1'b1, 1'b1, 16'h0, 1'b0, 2'b00};
            tag_h_q.push_back(-1);
            tag_v_q.push_back(-1);
            mh     = 0;
            mv     = 0;
            mmode  = 0;
            ms     = 0;
            msolid = 16'h0;
        end else begin
            e = model_pixel(mh, mv, mmode, msolid, ms);
            tag_h_q.push_back(mh);
            tag_v_q.push_back(mv);
            if (mh == HT - 1 && mv == VT - 1) begin
                mmode  = int'(bus.Mode);
                msolid = bus.SolidColor;
`ifdef LCD_PATTERN_SCROLL_EN
                ms     = (ms + 1) % HA;
`endif
            end
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            e[1:0] = mmode[1:0];
        end
        exp_q.push_back(e);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int h, input int v);
        int k;
        k = 0;
        while (!(mh == h && mv == v) && k < 2 * FRAME) begin
            tick();
            k++;
        end
        n_tests++;
        if (!(mh == h && mv == v)) begin
            n_fail++;
            $display("FAIL run_to: raster at h=%0d v=%0d, required h=%0d v=%0d", mh, mv, h, v);
        end
    endtask

    always @(negedge clk) begin
        logic [21:0] e, a;
        int          th, tv;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            th = tag_h_q.pop_front();
            tv = tag_v_q.pop_front();
            a  = {bus.LCD_DE, bus.LCD_HSYNC, bus.LCD_VSYNC, bus.LCD_R, bus.LCD_G, bus.LCD_B,
                  bus.FrameStart, bus.ActiveMode};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL pixel h=%0d v=%0d t=%0t: got de/hs/vs=%b%b%b rgb=%h fs=%b am=%0d, want de/hs/vs=%b%b%b rgb=%h fs=%b am=%0d",
                         th, tv, $time, a[21], a[20], a[19], a[18:3], a[2], a[1:0],
                         e[21], e[20], e[19], e[18:3], e[2], e[1:0]);
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.Mode       = 2'd0;
        bus.SolidColor = 16'h0;
        run(3);
        rst = 1'b0;

        // Timing and colour bars over two full frames
        run(2 * FRAME);

        // Mid-frame switch to solid colour takes effect at the next frame
        run_to(5, 3);
        bus.Mode       = 2'd1;
        bus.SolidColor = 16'h1234;
        run(2 * FRAME);

        bus.Mode = 2'd2;
        run(2 * FRAME);
        bus.Mode = 2'd3;
        run(2 * FRAME);

        // Reset mid-frame: blanking immediately, restart in bars mode
        run_to(9, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(2 * FRAME);

        // Randomised mode/colour changes with occasional resets
        for (int i = 0; i < 10 * FRAME; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                bus.Mode       = 2'($urandom_range(0, 3));
                bus.SolidColor = 16'($urandom);
            end
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;

        // Bars over enough frames to wrap any scroll offset
        bus.Mode = 2'd0;
        run(18 * FRAME);

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_timing_pattern_gen.md
Name: lcd_timing_pattern_gen

Overview:
Parametrised successor to the fixed 480x272 LCD timing and colour-bar source.
- Generates HSYNC/VSYNC/DE for any panel geometry with an explicit sync pulse and programmable sync polarity.
- Produces one of four selectable test patterns, with the mode latched only at frame boundaries.
- Sits directly in front of the RGB LCD pins, clocked by the pixel clock. All outputs are registered.

Parameters:
- H_ACTIVE, 480: visible pixels per line.
- H_FP, 50: horizontal front porch, in pixels.
- H_SYNC, 4: HSYNC pulse width, in pixels.
- H_BP, 30: horizontal back porch, in pixels.
- V_ACTIVE, 272: visible lines.
- V_FP, 20: vertical front porch, in lines.
- V_SYNC, 2: VSYNC pulse width, in lines.
- V_BP, 5: vertical back porch, in lines.
- HS_POL, 0: HSYNC active level.
- VS_POL, 0: VSYNC active level.
- GRID_PITCH, 16: grid and checker cell size in pixels, ≥2.
- CW, 16: counter width; must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- PixelClk, in, 1: pixel clock; the only clock.
- RST, in, 1: synchronous, active-high reset.
- Mode, in, 2: pattern select. 0 = bars, 1 = solid, 2 = grid, 3 = checker.
- SolidColor, in, 16: RGB565 value used in mode 1.
- LCD_DE, out, 1: display enable.
- LCD_HSYNC, out, 1: horizontal sync.
- LCD_VSYNC, out, 1: vertical sync.
- LCD_R, out, 5: red channel.
- LCD_G, out, 6: green channel.
- LCD_B, out, 5: blue channel.
- FrameStart, out, 1: one-cycle pulse coincident with output pixel (0,0) of the total raster.
- ActiveMode, out, 2: mode currently being displayed.

Behaviour:
- Clocking and reset: one clock (PixelClk); reset is synchronous and active-high (RST).
- Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, and wraps to 0 after V_TOTAL-1.
  - Line and frame order: sync, back porch, active, front porch.
- Decode, from the counters:
  - hs_act = h_cnt < H_SYNC; vs_act = v_cnt < V_SYNC.
  - de = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
  - x = h_cnt-(H_SYNC+H_BP); y = v_cnt-(V_SYNC+V_BP).
- Output stage: a single register stage. Every output reflects the counter state of the previous cycle, giving latency 1 for all outputs. Sync, DE and colour stay mutually aligned.
- Sync levels: LCD_HSYNC = hs_act ? HS_POL : ~HS_POL. VSYNC is formed the same way.
- Reset: counters go to 0 and ActiveMode to 0. On the reset cycle and the cycle after, outputs are:
  - LCD_DE=0, FrameStart=0, RGB=0.
  - HSYNC=~HS_POL, VSYNC=~VS_POL.
  - Counting starts at h=0,v=0 on the first cycle after RST deasserts. Reset mid-frame aborts the frame immediately; no partial-line completion.
- Mode latch: Mode is sampled into ActiveMode only when h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1, so a new mode takes effect from the next frame. Mode changes at any other time are ignored until that point. SolidColor is sampled at the same point.
- Colour: outside de, RGB=0. Inside de:
  - Mode 0: 8 vertical bars, bar width BW=H_ACTIVE/8, bar index = min(x/BW,7). Colours are red, green, blue, yellow, magenta, cyan, white, gray {10h,20h,10h}. The last bar absorbs the remainder pixels. Implemented with a BW down-counter, not a divider.
  - Mode 1: latched SolidColor.
  - Mode 2: white where x%GRID_PITCH==0 or y%GRID_PITCH==0, else black.
  - Mode 3: white when (x/GRID_PITCH ^ y/GRID_PITCH) bit0 = 1, else black.
  - Implementation: modes 2 and 3 use column/row pitch counters reset at the start of active x and active y. No multipliers or dividers in RTL.
- FrameStart: pulses in the output cycle where h_cnt was 0 and v_cnt was 0.

Optional Feature:
- Macro: LCD_PATTERN_SCROLL_EN.
- When defined: a scroll offset register s (CW bits) increments by 1 at each mode-latch point and wraps to 0 at H_ACTIVE. Modes 0, 2 and 3 use xs = (x+s) mod H_ACTIVE in place of x, so the pattern moves left 1 pixel/frame. Mode 1 is unaffected. Reset clears s to 0.
- When undefined: s is absent, xs = x, and the pattern is static.

Decomposition:
- Package lcd_pkg:
  - mode enum: MODE_BARS, MODE_SOLID, MODE_GRID, MODE_CHECK.
  - RGB565 widths R_W=5, G_W=6, B_W=5.
  - Colour constants: RED, GREEN, BLUE, YELLOW, MAGENTA, CYAN, WHITE, GRAY, BLACK.
- Sub-module lcd_pattern_src: takes de, x/y advance strobes, line start and ActiveMode. Returns RGB565 combinationally; owns the bar and pitch counters and the scroll offset. The top module holds the timing counters, decode and output register.

Test Plan:
- Bench parameters for all scenarios: H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, GRID_PITCH=4.
1. Reset, then run 2 frames → HSYNC low for cycles 1–2 of each 22-cycle line. VSYNC low for 1 line of 7. DE high 16 cycles × 4 lines per frame. FrameStart every 154 cycles.
2. Mode=0 → per active line, 2 pixels each in the order red F800, green 07E0, blue 001F, yellow FFE0, magenta F81F, cyan 07FF, white FFFF, gray 8410. RGB=0 outside DE.
3. Mode switched 0→1 (SolidColor=1234h) mid-frame → current frame stays bars. Next frame is all 1234h. ActiveMode changes in the cycle after the latch point.
4. Mode=2 and Mode=3 → grid white at x∈{0,4,8,12} or y=0. Checker row 0 is x 0–3 black, 4–7 white. Row y=1 is the same.
5. RST asserted at h=9,v=3, held 1 cycle → next cycle DE=0, syncs inactive. After release, FrameStart follows exactly 1 cycle after counting resumes, and the pattern restarts at mode 0.
6. With LCD_PATTERN_SCROLL_EN, Mode=0 → frame N line first pixel colour = bar[(N)/2 mod 8]. s wraps 15→0.
